// File: rtl/com_pixel_feeder.sv
// com_pixel_feeder: producer side of the center_of_mass pixel interface.
// Forwards in-ROI masked pixels, pulses tabulate_out once per frame after a
// flush gap, then waits for com_valid_in. A frame already in progress when the
// result arrives is skipped whole.
// Ports: clk_in, rst_in (async, active low); hcount_in/vcount_in/pix_valid_in/
// mask_in pixel stream; com_valid_in result ready; x_out/y_out/valid_out and
// tabulate_out to center_of_mass; frame_pixels_out, frame_count_out,
// dropped_out, timeout_out status.
module com_pixel_feeder #(
  parameter int H_ACTIVE     = 1024,
  parameter int V_ACTIVE     = 768,
  parameter int ROI_X_MIN    = 0,
  parameter int ROI_X_MAX    = 1023,
  parameter int ROI_Y_MIN    = 0,
  parameter int ROI_Y_MAX    = 767,
  parameter int TAB_GAP      = 8,
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pix_valid_in,
  input  logic        mask_in,
  input  logic        com_valid_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        tabulate_out,
  output logic [19:0] frame_pixels_out,
  output logic [15:0] frame_count_out,
  output logic        dropped_out,
  output logic        timeout_out
);

  localparam int GW = (TAB_GAP > 1) ? $clog2(TAB_GAP) : 1;
  localparam int WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_MIN  = 11'(ROI_X_MIN);
  localparam logic [10:0] X_MAX  = 11'(ROI_X_MAX);
  localparam logic [9:0]  Y_MIN  = 10'(ROI_Y_MIN);
  localparam logic [9:0]  Y_MAX  = 10'(ROI_Y_MAX);

  localparam logic [GW-1:0] GAP_LAST  = GW'(TAB_GAP - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    SYNC,
    SCAN,
    GAP,
    TAB,
    WAIT,
    SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          valid_q, valid_d;
  logic [19:0]   pix_cnt_q, pix_cnt_d;
  logic [19:0]   fpix_q, fpix_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          seen_q, seen_d;

  logic fe;
  logic hit;
  logic seen_now;
  logic dropped;
  logic timeout;

  assign fe = pix_valid_in
           && (hcount_in == H_LAST)
           && (vcount_in == V_LAST);

  assign hit = pix_valid_in && mask_in
            && (hcount_in >= X_MIN)
            && (hcount_in <= X_MAX)
            && (vcount_in >= Y_MIN)
            && (vcount_in <= Y_MAX);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    pix_cnt_d = pix_cnt_q;
    fpix_d    = fpix_q;
    fcnt_d    = fcnt_q;
    gap_d     = gap_q;
    wait_d    = wait_q;
    seen_d    = seen_q;
    seen_now  = 1'b0;
    dropped   = 1'b0;
    timeout   = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (fe) state_d = SCAN;
      end

      SCAN: begin
        if (hit) begin
          x_d     = hcount_in;
          y_d     = vcount_in;
          valid_d = 1'b1;
          if (pix_cnt_q != '1)
            pix_cnt_d = pix_cnt_q + 20'd1;
        end
        if (fe) begin
          gap_d = '0;
          // With no flush gap, TAB follows fe directly so the
          // fe-to-tabulate distance stays TAB_GAP+1.
          state_d = (TAB_GAP == 0) ? TAB : GAP;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST)
          state_d = TAB;
        else
          gap_d = gap_q + 1'b1;
      end

      TAB: begin
        fpix_d    = pix_cnt_q;
        pix_cnt_d = '0;
        fcnt_d    = fcnt_q + 16'd1;
        seen_d    = 1'b0;
        wait_d    = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        // A pixel this cycle already makes the next frame partial.
        seen_now = seen_q | pix_valid_in;
        seen_d   = seen_now;
        if (com_valid_in) begin
          state_d = seen_now ? SKIP : SCAN;
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = seen_now ? SKIP : SCAN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      SKIP: begin
        if (fe) begin
          dropped = 1'b1;
          state_d = SCAN;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= SYNC;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      pix_cnt_q <= '0;
      fpix_q    <= '0;
      fcnt_q    <= '0;
      gap_q     <= '0;
      wait_q    <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      pix_cnt_q <= pix_cnt_d;
      fpix_q    <= fpix_d;
      fcnt_q    <= fcnt_d;
      gap_q     <= gap_d;
      wait_q    <= wait_d;
      seen_q    <= seen_d;
    end
  end

  assign x_out            = x_q;
  assign y_out            = y_q;
  assign valid_out        = valid_q;
  assign tabulate_out     = (state_q == TAB);
  assign frame_pixels_out = fpix_q;
  assign frame_count_out  = fcnt_q;
  assign dropped_out      = dropped;
  assign timeout_out      = timeout;

endmodule

// File: tb/tb_com_pixel_feeder.sv
// tb_com_pixel_feeder: directed frames against an event schedule
// built from the stream the bench drives.
module tb_com_pixel_feeder;

  localparam int H    = 16;
  localparam int V    = 8;
  localparam int XMIN = 3;
  localparam int XMAX = 12;
  localparam int YMIN = 2;
  localparam int YMAX = 5;
  localparam int GAP  = 3;
  localparam int TO   = 20;
  localparam int NS   = 8192;

  logic        clk_in;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        pix_valid_in;
  logic        mask_in;
  logic        com_valid_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        tabulate_out;
  logic [19:0] frame_pixels_out;
  logic [15:0] frame_count_out;
  logic        dropped_out;
  logic        timeout_out;

  com_pixel_feeder #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .ROI_X_MIN(XMIN), .ROI_X_MAX(XMAX),
    .ROI_Y_MIN(YMIN), .ROI_Y_MAX(YMAX),
    .TAB_GAP(GAP), .WAIT_TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .pix_valid_in(pix_valid_in),
    .mask_in(mask_in),
    .com_valid_in(com_valid_in),
    .x_out(x_out),
    .y_out(y_out),
    .valid_out(valid_out),
    .tabulate_out(tabulate_out),
    .frame_pixels_out(frame_pixels_out),
    .frame_count_out(frame_count_out),
    .dropped_out(dropped_out),
    .timeout_out(timeout_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Expected events per slot (slot = cycle whose inputs are
  // sampled at the next rising edge).
  bit          exp_v[NS];
  logic [10:0] exp_x[NS];
  logic [9:0]  exp_y[NS];
  bit          exp_tab[NS];
  bit          exp_drop[NS];
  bit          exp_to[NS];

  int          errors = 0;
  int          checks = 0;
  int          last_tab = 0;
  int          mcnt = 0;
  int          fp_q[$];
  logic [19:0] cur_fp = '0;
  logic [15:0] cur_fc = '0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s cycle %0d: got %0d want %0d",
                 nm, cyc, got, want);
    end
  endtask

  always @(negedge clk_in) begin
    if (cyc < NS) begin
      chk("valid_out", 32'(valid_out), 32'(exp_v[cyc]));
      if (exp_v[cyc]) begin
        chk("x_out", 32'(x_out), 32'(exp_x[cyc]));
        chk("y_out", 32'(y_out), 32'(exp_y[cyc]));
      end
      chk("tabulate_out", 32'(tabulate_out), 32'(exp_tab[cyc]));
      chk("dropped_out", 32'(dropped_out), 32'(exp_drop[cyc]));
      chk("timeout_out", 32'(timeout_out), 32'(exp_to[cyc]));
      chk("frame_pixels", 32'(frame_pixels_out), 32'(cur_fp));
      chk("frame_count", 32'(frame_count_out), 32'(cur_fc));
      if (exp_tab[cyc]) begin
        if (fp_q.size() > 0) cur_fp = 20'(fp_q.pop_front());
        cur_fc = cur_fc + 16'd1;
      end
    end
  end

  task automatic drive(input bit pv, input int x, input int y,
                       input bit m, input bit cv);
    @(posedge clk_in);
    #1;
    pix_valid_in = pv;
    hcount_in    = 11'(x);
    vcount_in    = 10'(y);
    mask_in      = m;
    com_valid_in = cv;
  endtask

  // mode: 0 no mask, 1 all mask, 2 only (px,py),
  // 3 columns 2,3,12,13 (straddling the ROI x edges)
  task automatic frame(input int start, input int mode,
                       input bit fwd, input bit drp,
                       input int cv_idx, input int px, input int py);
    mcnt = 0;
    for (int i = start; i < H * V; i++) begin
      int x;
      int y;
      int s;
      bit m;
      x = i % H;
      y = i / H;
      m = (mode == 1)
       || (mode == 2 && x == px && y == py)
       || (mode == 3 && (x == 2 || x == 3 || x == 12 || x == 13));
      drive(1'b1, x, y, m, i == cv_idx);
      s = cyc;
      if (fwd && m && x >= XMIN && x <= XMAX
          && y >= YMIN && y <= YMAX) begin
        exp_v[s + 1] = 1'b1;
        exp_x[s + 1] = 11'(x);
        exp_y[s + 1] = 10'(y);
        mcnt++;
      end
      if (i == H * V - 1) begin
        if (fwd) begin
          last_tab = s + GAP + 1;
          exp_tab[last_tab] = 1'b1;
          fp_q.push_back(mcnt);
        end
        if (drp) exp_drop[s] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic handshake();
    idle(6);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    @(negedge clk_in);
    chk(nm, got, want);
  endtask

  initial begin
    rst_in       = 1'b0;
    hcount_in    = '0;
    vcount_in    = '0;
    pix_valid_in = 1'b0;
    mask_in      = 1'b0;
    com_valid_in = 1'b0;

    // Pixels stream while in reset; reset lifts mid-frame.
    for (int i = 0; i < 41; i++) begin
      drive(1'b1, i % H, i / H, 1'b1, 1'b1);
      if (i == 20) begin
        @(negedge clk_in);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_tab", 32'(tabulate_out), 0);
        chk("rst_fpix", 32'(frame_pixels_out), 0);
        chk("rst_fcnt", 32'(frame_count_out), 0);
      end
    end
    rst_in = 1'b1;
    frame(41, 1, 1'b0, 1'b0, -1, 0, 0);

    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    handshake();
    lit("roi_fpix", 32'(frame_pixels_out), 40);
    lit("roi_fcnt", 32'(frame_count_out), 1);

    frame(0, 2, 1'b1, 1'b0, -1, 5, 3);
    handshake();
    lit("single_fpix", 32'(frame_pixels_out), 1);
    lit("single_x", 32'(x_out), 5);
    lit("single_y", 32'(y_out), 3);

    frame(0, 2, 1'b1, 1'b0, -1, 1, 1);
    handshake();
    lit("outside_fpix", 32'(frame_pixels_out), 0);

    frame(0, 0, 1'b1, 1'b0, -1, 0, 0);
    handshake();
    lit("nomask_fpix", 32'(frame_pixels_out), 0);
    lit("nomask_fcnt", 32'(frame_count_out), 4);

    frame(0, 3, 1'b1, 1'b0, -1, 0, 0);
    handshake();
    lit("edge_fpix", 32'(frame_pixels_out), 8);

    // Result arrives after the next frame started: skipped.
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    idle(6);
    frame(0, 1, 1'b0, 1'b1, 2, 0, 0);
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    handshake();
    lit("skip_fcnt", 32'(frame_count_out), 7);

    // Timeout with no pixels seen: straight back to SCAN.
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    exp_to[last_tab + TO] = 1'b1;
    idle(30);
    frame(0, 2, 1'b1, 1'b0, -1, 7, 4);
    handshake();
    lit("to_fpix", 32'(frame_pixels_out), 1);
    lit("to_fcnt", 32'(frame_count_out), 9);

    // Timeout with pixels seen: the running frame is skipped.
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    exp_to[last_tab + TO] = 1'b1;
    frame(0, 1, 1'b0, 1'b1, -1, 0, 0);
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    handshake();

    // Result and frame-end pixel in the same WAIT cycle.
    frame(0, 1, 1'b1, 1'b0, -1, 0, 0);
    idle(6);
    frame(H * V - 1, 1, 1'b0, 1'b0, H * V - 1, 0, 0);
    frame(0, 1, 1'b0, 1'b1, -1, 0, 0);
    frame(0, 3, 1'b1, 1'b0, -1, 0, 0);
    handshake();
    idle(8);
    lit("end_fpix", 32'(frame_pixels_out), 8);
    lit("end_fcnt", 32'(frame_count_out), 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
